// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types for the dcache commit-side miss engine: request opcodes, tag word and FSM states.
package dcache_miss_ctrl_pkg;

  localparam int MC_WORDS_PER_LINE = 4;
  localparam int MC_WAY_NUM        = 2;
  localparam int MC_TAG_W          = 20;

  typedef enum logic [1:0] {
    LOAD_MISS  = 2'd0,
    STORE_MISS = 2'd1,
    UC_LOAD    = 2'd2,
    UC_STORE   = 2'd3
  } miss_op_e;

  typedef struct packed {
    logic [MC_TAG_W-1:0] tag;
    logic                v;
    logic                d;
  } cache_tag_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_REQ,
    S_WB_DATA,
    S_RF_REQ,
    S_RF_DATA,
    S_RF_TAG,
    S_UC_REQ,
    S_UC_DATA,
    S_UC_RD,
    S_DONE
  } miss_state_e;

  // Byte-lane merge: lanes with strb set take new_w, the rest keep old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_line_buffer.sv
// Victim line buffer: WORDS x 32 register file, one write port, one combinational read port.
module dcache_miss_ctrl_line_buffer #(
  parameter int WORDS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Commit-side miss/uncached engine: victim writeback, line refill with store merge, uncached single beats.
// Multi-cycle per request; req_ready only in IDLE, bus request/write beats held until accepted.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int WORDS_PER_LINE = MC_WORDS_PER_LINE,
  parameter int WAY_NUM        = MC_WAY_NUM,
  parameter int TAG_W          = MC_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [31:0]        req_paddr,
  input  logic [WAY_NUM-1:0] req_way,
  input  logic               req_dirty,
  input  logic [31:0]        req_dirty_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_strb,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic [WAY_NUM-1:0] cache_way,
  output logic [31:0]        cache_addr,
  output logic               cache_tag_we,
  output logic [TAG_W+1:0]   cache_tag_data,
  output logic [3:0]         cache_strb,
  output logic [31:0]        cache_wdata,
  input  logic [31:0]        cache_rdata,
  output logic               bus_req_valid,
  input  logic               bus_req_ready,
  output logic               bus_we,
  output logic [31:0]        bus_addr,
  output logic [1:0]         bus_len,
  output logic               bus_wvalid,
  input  logic               bus_wready,
  output logic [31:0]        bus_wdata,
  output logic [3:0]         bus_wstrb,
  output logic               bus_wlast,
  input  logic               bus_rvalid,
  input  logic [31:0]        bus_rdata,
  input  logic               bus_rlast
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = IDX_W + 2;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] RD_CYCLES = CNT_W'(WORDS_PER_LINE);
  localparam logic [1:0]       LINE_LEN  = 2'(WORDS_PER_LINE - 1);

  miss_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  miss_op_e           r_op;
  logic [WAY_NUM-1:0] r_way;
  logic [31:OFF_W]    r_dirty_line;
  logic [31:2]        r_paddr_w;
  logic [31:0]        r_wdata;
  logic [3:0]         r_strb;
  logic [31:0]        r_rdata, w_rdata_nxt;

  logic               w_accept;
  logic [IDX_W-1:0]   w_word_idx;
  logic               w_hit_word;
  logic [CNT_W-1:0]   w_cnt_m1;
  logic               w_buf_we;
  logic [31:0]        w_buf_rdata;
  cache_tag_t         w_tag;
  logic               w_unused;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_word_idx = r_cnt[IDX_W-1:0];
  assign w_hit_word = (w_word_idx == r_paddr_w[OFF_W-1:2]);
  assign w_cnt_m1   = r_cnt - CNT_W'(1);
  assign w_tag      = '{tag: r_paddr_w[31:32-TAG_W], v: 1'b1, d: (r_op == STORE_MISS)};
  assign w_unused   = &{1'b0, req_paddr[1:0], req_dirty_addr[OFF_W-1:0]};
  assign resp_rdata = r_rdata;

  // Cache read data lags the address by one cycle, so WB_RD cycle k stores word k-1.
  assign w_buf_we = (r_state == S_WB_RD) && (r_cnt != '0);

  dcache_miss_ctrl_line_buffer #(
    .WORDS (WORDS_PER_LINE),
    .IDX_W (IDX_W)
  ) u_victim_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_buf_we),
    .i_waddr (w_cnt_m1[IDX_W-1:0]),
    .i_wdata (cache_rdata),
    .i_raddr (w_word_idx),
    .o_rdata (w_buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op         <= LOAD_MISS;
      r_way        <= '0;
      r_dirty_line <= '0;
      r_paddr_w    <= '0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_accept) begin
        r_op         <= miss_op_e'(req_op);
        r_way        <= req_way;
        r_dirty_line <= req_dirty_addr[31:OFF_W];
        r_paddr_w    <= req_paddr[31:2];
        r_wdata      <= req_wdata;
        r_strb       <= (miss_op_e'(req_op) == UC_LOAD) ? 4'hF : req_strb;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rdata_nxt    = r_rdata;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    cache_way      = '0;
    cache_addr     = '0;
    cache_tag_we   = 1'b0;
    cache_tag_data = '0;
    cache_strb     = '0;
    cache_wdata    = '0;
    bus_req_valid  = 1'b0;
    bus_we         = 1'b0;
    bus_addr       = '0;
    bus_len        = '0;
    bus_wvalid     = 1'b0;
    bus_wdata      = '0;
    bus_wstrb      = '0;
    bus_wlast      = 1'b0;

    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_cnt_nxt = '0;
          case (miss_op_e'(req_op))
            UC_LOAD, UC_STORE: w_state_nxt = S_UC_REQ;
            default:           w_state_nxt = req_dirty ? S_WB_RD : S_RF_REQ;
          endcase
        end
      end

      S_WB_RD: begin
        cache_way  = r_way;
        cache_addr = {r_dirty_line, w_word_idx, 2'b00};
        if (r_cnt == RD_CYCLES) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WB_REQ;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_WB_REQ: begin
        bus_req_valid = 1'b1;
        bus_we        = 1'b1;
        bus_addr      = {r_dirty_line, OFF_W'(0)};
        bus_len       = LINE_LEN;
        if (bus_req_ready) w_state_nxt = S_WB_DATA;
      end

      S_WB_DATA: begin
        bus_wvalid = 1'b1;
        bus_wdata  = w_buf_rdata;
        bus_wstrb  = 4'hF;
        bus_wlast  = (w_word_idx == LAST_IDX);
        if (bus_wready) begin
          if (w_word_idx == LAST_IDX) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RF_REQ;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      S_RF_REQ: begin
        bus_req_valid = 1'b1;
        bus_addr      = {r_paddr_w[31:OFF_W], OFF_W'(0)};
        bus_len       = LINE_LEN;
        if (bus_req_ready) w_state_nxt = S_RF_DATA;
      end

      S_RF_DATA: begin
        if (bus_rvalid) begin
          cache_way   = r_way;
          cache_addr  = {r_paddr_w[31:OFF_W], w_word_idx, 2'b00};
          cache_strb  = 4'hF;
          cache_wdata = bus_rdata;
          if (w_hit_word && (r_op == STORE_MISS))
            cache_wdata = merge_bytes(bus_rdata, r_wdata, r_strb);
          if (w_hit_word && (r_op == LOAD_MISS))
            w_rdata_nxt = bus_rdata;
          // Extra beats past the line end keep hitting the last word instead of wrapping.
          if (w_word_idx != LAST_IDX) w_cnt_nxt = r_cnt + CNT_W'(1);
          if (bus_rlast) w_state_nxt = S_RF_TAG;
        end
      end

      S_RF_TAG: begin
        cache_way      = r_way;
        cache_addr     = {r_paddr_w[31:OFF_W], OFF_W'(0)};
        cache_tag_we   = 1'b1;
        cache_tag_data = w_tag;
        w_state_nxt    = S_DONE;
      end

      S_UC_REQ: begin
        bus_req_valid = 1'b1;
        bus_we        = (r_op == UC_STORE);
        bus_addr      = {r_paddr_w, 2'b00};
        bus_len       = 2'd0;
        if (bus_req_ready) w_state_nxt = (r_op == UC_STORE) ? S_UC_DATA : S_UC_RD;
      end

      S_UC_DATA: begin
        bus_wvalid = 1'b1;
        bus_wdata  = r_wdata;
        bus_wstrb  = r_strb;
        bus_wlast  = 1'b1;
        if (bus_wready) w_state_nxt = S_DONE;
      end

      S_UC_RD: begin
        if (bus_rvalid) begin
          w_rdata_nxt = bus_rdata;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        resp_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: directed requests push expected cache/bus/resp events, monitors pop and compare.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_paddr;
  logic [1:0]  req_way;
  logic        req_dirty;
  logic [31:0] req_dirty_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  cache_way;
  logic [31:0] cache_addr;
  logic        cache_tag_we;
  logic [21:0] cache_tag_data;
  logic [3:0]  cache_strb;
  logic [31:0] cache_wdata, cache_rdata;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr;
  logic [1:0]  bus_len;
  logic        bus_wvalid, bus_wready;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_wlast;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_rlast;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_paddr(req_paddr),
    .req_way(req_way), .req_dirty(req_dirty), .req_dirty_addr(req_dirty_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cache_way(cache_way), .cache_addr(cache_addr), .cache_tag_we(cache_tag_we),
    .cache_tag_data(cache_tag_data), .cache_strb(cache_strb), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_len(bus_len),
    .bus_wvalid(bus_wvalid), .bus_wready(bus_wready), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_wlast(bus_wlast),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rlast(bus_rlast)
  );

  typedef struct {logic [1:0] way; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;
                  logic tag_we; logic [21:0] tag;} cwr_t;
  typedef struct {logic we; logic [31:0] addr; logic [1:0] len;} breq_t;
  typedef struct {logic [31:0] d; logic [3:0] s; logic l;} wbeat_t;
  typedef struct {logic chk_d; logic [31:0] d; logic chk_gap;} resp_t;

  cwr_t   cwr_q[$];
  breq_t  breq_q[$];
  wbeat_t wb_q[$];
  resp_t  resp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] vict [4];

  int n_vec = 0, n_err = 0;
  int cyc = 0, tag_cyc = 0, resp_cyc = 0, n_resp = 0, acc_cyc = 0;
  int stall_beat = -1, stall_len = 0;
  logic [31:0] stall_exp = '0;
  int rbeats = 0;
  logic [1:0] cur_len = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cache data array model: registered read of the victim line.
  initial begin
    cache_rdata = '0;
    forever begin
      @(posedge clk);
      cache_rdata <= vict[cache_addr[3:2]];
    end
  end

  // Bus slave: one-cycle request accept, read beats from rd_q, optional wready stall.
  logic       s_we;
  logic [1:0] s_len;
  initial begin
    bus_req_ready = 0; bus_wready = 0; bus_rvalid = 0; bus_rdata = '0; bus_rlast = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus_req_valid) begin
        s_we = bus_we; s_len = bus_len;
        bus_req_ready = 1;
        @(posedge clk); #1;
        bus_req_ready = 0;
        if (s_we) begin
          for (int i = 0; i <= int'(s_len); i++) begin
            if (i == stall_beat) begin
              bus_wready = 0;
              for (int s = 0; s < stall_len; s++) begin
                @(negedge clk);
                chk("stall_wvalid", 32'(bus_wvalid), 32'd1);
                chk("stall_wdata", bus_wdata, stall_exp);
                @(posedge clk); #1;
              end
            end
            bus_wready = 1;
            @(posedge clk); #1;
          end
          bus_wready = 0;
        end else begin
          for (int i = 0; i <= int'(s_len); i++) begin
            if (rst) break;
            bus_rvalid = 1;
            bus_rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
            bus_rlast  = (i == int'(s_len));
            @(posedge clk); #1;
          end
          bus_rvalid = 0; bus_rlast = 0; bus_rdata = '0;
        end
      end
    end
  end

  // Monitor: pops expected events whenever the DUT presents one.
  cwr_t ce; breq_t be; wbeat_t we_e; resp_t re;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cache_strb != 4'h0 || cache_tag_we) begin
        if (cwr_q.size() == 0) chk("unexpected_cache_write", cache_addr, 32'hFFFF_FFFF);
        else begin
          ce = cwr_q.pop_front();
          chk("cache_tag_we", 32'(cache_tag_we), 32'(ce.tag_we));
          chk("cache_way", 32'(cache_way), 32'(ce.way));
          if (ce.tag_we) begin
            chk("cache_tag_data", 32'(cache_tag_data), 32'(ce.tag));
            tag_cyc = cyc;
          end else begin
            chk("cache_addr", cache_addr, ce.addr);
            chk("cache_strb", 32'(cache_strb), 32'(ce.strb));
            chk("cache_wdata", cache_wdata, ce.wdata);
          end
        end
      end
      if (bus_req_valid && bus_req_ready) begin
        cur_len = bus_len; rbeats = 0;
        if (breq_q.size() == 0) chk("unexpected_bus_req", bus_addr, 32'hFFFF_FFFF);
        else begin
          be = breq_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(be.we));
          chk("bus_addr", bus_addr, be.addr);
          chk("bus_len", 32'(bus_len), 32'(be.len));
        end
      end
      if (bus_wvalid && bus_wready) begin
        if (wb_q.size() == 0) chk("unexpected_wbeat", bus_wdata, 32'hFFFF_FFFF);
        else begin
          we_e = wb_q.pop_front();
          chk("bus_wdata", bus_wdata, we_e.d);
          chk("bus_wstrb", 32'(bus_wstrb), 32'(we_e.s));
          chk("bus_wlast", 32'(bus_wlast), 32'(we_e.l));
        end
      end
      if (bus_rvalid) begin
        if (bus_rlast) chk("rlast_beat", 32'(rbeats), 32'(cur_len));
        rbeats++;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        n_resp++;
        if (resp_q.size() == 0) chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
        else begin
          re = resp_q.pop_front();
          if (re.chk_d) chk("resp_rdata", resp_rdata, re.d);
          if (re.chk_gap) chk("resp_after_tag", 32'(cyc), 32'(tag_cyc + 1));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] pa, input logic [1:0] way,
                       input logic dirty, input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] st, input bit hold);
    int t;
    req_op = op; req_paddr = pa; req_way = way; req_dirty = dirty;
    req_dirty_addr = da; req_wdata = wd; req_strb = st; req_valid = 1;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (t == 300) chk("accept_timeout", 32'd1, 32'd0);
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) req_valid = 0;
  endtask

  task automatic wait_resp(input int target);
    for (int t = 0; t < 400 && n_resp < target; t++) @(negedge clk);
    chk("resp_count", 32'(n_resp), 32'(target));
  endtask

  function automatic cwr_t cw(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    cwr_t c;
    c.way = w; c.addr = a; c.strb = 4'hF; c.wdata = d; c.tag_we = 0; c.tag = '0;
    return c;
  endfunction

  function automatic cwr_t tw(input logic [1:0] w, input logic [21:0] tg);
    cwr_t c;
    c.way = w; c.addr = '0; c.strb = 4'h0; c.wdata = '0; c.tag_we = 1; c.tag = tg;
    return c;
  endfunction

  initial begin
    rst = 1; req_valid = 0; req_op = 0; req_paddr = 0; req_way = 0; req_dirty = 0;
    req_dirty_addr = 0; req_wdata = 0; req_strb = 0;
    for (int i = 0; i < 4; i++) vict[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_bus_wvalid", 32'(bus_wvalid), 32'd0);
    chk("rst_cache_strb", 32'(cache_strb), 32'd0);
    chk("rst_cache_tag_we", 32'(cache_tag_we), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // Clean load miss
    rd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    breq_q.push_back('{1'b0, 32'h0000_1230, 2'd3});
    cwr_q.push_back(cw(2'b01, 32'h1230, 32'hA0));
    cwr_q.push_back(cw(2'b01, 32'h1234, 32'hA1));
    cwr_q.push_back(cw(2'b01, 32'h1238, 32'hA2));
    cwr_q.push_back(cw(2'b01, 32'h123C, 32'hA3));
    cwr_q.push_back(tw(2'b01, 22'h000006));
    resp_q.push_back('{1'b1, 32'hA1, 1'b1});
    issue(2'd0, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    wait_resp(1);

    // Dirty store miss with a 3-cycle wready stall on write beat 1
    vict[0] = 32'h11; vict[1] = 32'h22; vict[2] = 32'h33; vict[3] = 32'h44;
    stall_beat = 1; stall_len = 3; stall_exp = 32'h22;
    rd_q = '{32'h0A0B0C0D, 32'h1A1B1C1D, 32'h55667788, 32'h3A3B3C3D};
    breq_q.push_back('{1'b1, 32'h0008_0230, 2'd3});
    breq_q.push_back('{1'b0, 32'h0000_1230, 2'd3});
    wb_q.push_back('{32'h11, 4'hF, 1'b0});
    wb_q.push_back('{32'h22, 4'hF, 1'b0});
    wb_q.push_back('{32'h33, 4'hF, 1'b0});
    wb_q.push_back('{32'h44, 4'hF, 1'b1});
    cwr_q.push_back(cw(2'b10, 32'h1230, 32'h0A0B0C0D));
    cwr_q.push_back(cw(2'b10, 32'h1234, 32'h1A1B1C1D));
    cwr_q.push_back(cw(2'b10, 32'h1238, 32'h5566BEEF));
    cwr_q.push_back(cw(2'b10, 32'h123C, 32'h3A3B3C3D));
    cwr_q.push_back(tw(2'b10, 22'h000007));
    resp_q.push_back('{1'b0, 32'h0, 1'b1});
    issue(2'd1, 32'h0000_1238, 2'b10, 1'b1, 32'h0008_0230, 32'hDEADBEEF, 4'b0011, 0);
    wait_resp(2);
    stall_beat = -1;

    // Uncached store
    breq_q.push_back('{1'b1, 32'hBFAF_8000, 2'd0});
    wb_q.push_back('{32'h12345678, 4'b1000, 1'b1});
    resp_q.push_back('{1'b0, 32'h0, 1'b0});
    issue(2'd3, 32'hBFAF_8000, 2'b01, 1'b0, 32'h0, 32'h12345678, 4'b1000, 0);
    wait_resp(3);

    // Uncached load, byte address rounds down to the word
    rd_q.push_back(32'hCAFEF00D);
    breq_q.push_back('{1'b0, 32'hBFAF_8004, 2'd0});
    resp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0});
    issue(2'd2, 32'hBFAF_8006, 2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    wait_resp(4);

    // Reset during refill beat 2
    rd_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    breq_q.push_back('{1'b0, 32'h0000_2000, 2'd3});
    cwr_q.push_back(cw(2'b01, 32'h2000, 32'hB0));
    cwr_q.push_back(cw(2'b01, 32'h2004, 32'hB1));
    cwr_q.push_back(cw(2'b01, 32'h2008, 32'hB2));
    issue(2'd0, 32'h0000_2004, 2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cache_strb != 4'h0 && cache_addr == 32'h2008) break;
    end
    #1 rst = 1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_bus_req_valid", 32'(bus_req_valid), 32'd0);
    chk("midrst_cache_strb", 32'(cache_strb), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_cache_q_drained", 32'(cwr_q.size()), 32'd0);
    #1 rst = 0;
    rd_q.delete();
    repeat (10) @(negedge clk);
    chk("no_resp_after_rst", 32'(n_resp), 32'd4);
    @(posedge clk); #1;

    // Back-to-back with req_valid held high
    rd_q = '{32'h600D0001, 32'h600D0002};
    breq_q.push_back('{1'b0, 32'h0000_3000, 2'd0});
    breq_q.push_back('{1'b0, 32'h0000_3004, 2'd0});
    resp_q.push_back('{1'b1, 32'h600D0001, 1'b0});
    resp_q.push_back('{1'b1, 32'h600D0002, 1'b0});
    issue(2'd2, 32'h0000_3000, 2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 1);
    issue(2'd2, 32'h0000_3004, 2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    chk("b2b_accept_cycle", 32'(acc_cyc), 32'(resp_cyc + 1));
    wait_resp(6);

    repeat (5) @(negedge clk);
    chk("cwr_q_empty", 32'(cwr_q.size()), 32'd0);
    chk("breq_q_empty", 32'(breq_q.size()), 32'd0);
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
